// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b pipeline types for the memory stage.
//   lc3b_word          16-bit datapath word
//   lc3b_control_word  memory-control bits carried down the pipe
//   lc3b_mem_state     memory-stage FSM states
//   word_align()       clears address bit 0 for the word-addressed memory port
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_byte;
        logic mem_indirect;
    } lc3b_control_word;

    typedef enum logic [1:0] {
        IDLE,
        PTR,
        ACCESS,
        DONE
    } lc3b_mem_state;

    function automatic lc3b_word word_align(input lc3b_word a);
        return {a[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_stage_byte_align.sv
// mem_byte_align: combinational byte lane handling for loads and stores.
//   i_byte   byte-sized access
//   i_sel    address bit 0 (1 = high byte)
//   i_rdata  raw memory read word       -> o_load  zero-extended load result
//   i_sr2    store source register      -> o_wdata replicated store data
//                                       -> o_be    byte enables {high, low}
module mem_byte_align
    import lc3b_types::*;
(
    input  logic       i_byte,
    input  logic       i_sel,
    input  lc3b_word   i_rdata,
    input  lc3b_word   i_sr2,
    output lc3b_word   o_load,
    output lc3b_word   o_wdata,
    output logic [1:0] o_be
);

    assign o_load  = i_byte ? {8'h00, i_sel ? i_rdata[15:8] : i_rdata[7:0]} : i_rdata;
    // Byte stores put the byte on both lanes; the enable picks the lane.
    assign o_wdata = i_byte ? {2{i_sr2[7:0]}} : i_sr2;
    assign o_be    = i_byte ? (i_sel ? 2'b10 : 2'b01) : 2'b11;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: LC-3b MEM stage; runs LDR/STR/LDB/STB/LDI/STI on the data port.
//   clk, reset_n      clock, async active-low reset
//   control_in        memory control bits from EX/MEM
//   alu_in, sr2_in    effective address, store data
//   dmem_*            data memory request/response port
//   mdr_out           registered load result for MEM/WB
//   stall             freezes upstream barriers until the access completes
module mem_stage
    import lc3b_types::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  lc3b_control_word control_in,
    input  lc3b_word         alu_in,
    input  lc3b_word         sr2_in,
    input  logic             dmem_resp,
    input  lc3b_word         dmem_rdata,
    output logic             dmem_read,
    output logic             dmem_write,
    output lc3b_word         dmem_address,
    output lc3b_word         dmem_wdata,
    output logic [1:0]       dmem_byte_enable,
    output lc3b_word         mdr_out,
    output logic             stall
);

    lc3b_mem_state r_state, w_next;
    lc3b_word      r_ptr, r_mdr;
    lc3b_word      w_addr, w_load, w_wdata;
    logic [1:0]    w_be;
    logic          w_mem_op, w_is_write;

    assign w_mem_op   = control_in.mem_read | control_in.mem_write;
    // A write bit wins when both are set.
    assign w_is_write = control_in.mem_write;
    assign w_addr     = control_in.mem_indirect ? r_ptr : alu_in;

    mem_byte_align u_align (
        .i_byte  (control_in.mem_byte),
        .i_sel   (w_addr[0]),
        .i_rdata (dmem_rdata),
        .i_sr2   (sr2_in),
        .o_load  (w_load),
        .o_wdata (w_wdata),
        .o_be    (w_be)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_mdr   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == PTR && dmem_resp)
                r_ptr <= dmem_rdata;
            if (r_state == ACCESS && dmem_resp && !w_is_write)
                r_mdr <= w_load;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_mem_op ? (control_in.mem_indirect ? PTR : ACCESS) : IDLE;
            PTR:     w_next = dmem_resp ? ACCESS : PTR;
            ACCESS:  w_next = dmem_resp ? DONE : ACCESS;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_byte_enable = 2'b00;
        if (r_state == PTR) begin
            // Pointer fetch is always a full-word read.
            dmem_read        = 1'b1;
            dmem_address     = word_align(alu_in);
            dmem_byte_enable = 2'b11;
        end else if (r_state == ACCESS) begin
            dmem_read        = !w_is_write;
            dmem_write       = w_is_write;
            dmem_address     = word_align(w_addr);
            dmem_wdata       = w_is_write ? w_wdata : '0;
            dmem_byte_enable = w_be;
        end
    end

    // reset_n gates stall so it drops at once while reset is held.
    assign stall   = reset_n & ((r_state == IDLE && w_mem_op) || r_state == PTR || r_state == ACCESS);
    assign mdr_out = r_mdr;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
    import lc3b_types::*;

    logic             clk = 1'b0;
    logic             reset_n;
    lc3b_control_word control_in;
    lc3b_word         alu_in, sr2_in, dmem_rdata;
    logic             dmem_resp;
    logic             dmem_read, dmem_write, stall;
    lc3b_word         dmem_address, dmem_wdata, mdr_out;
    logic [1:0]       dmem_byte_enable;

    int n_tests = 0;
    int n_fail  = 0;

    int         n_req, n_stall;
    logic [15:0] q_addr [2];
    logic [15:0] q_wdata [2];
    logic [1:0]  q_be [2];
    logic        q_rd [2];
    logic        q_wr [2];

    mem_stage dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .control_in       (control_in),
        .alu_in           (alu_in),
        .sr2_in           (sr2_in),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .mdr_out          (mdr_out),
        .stall            (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic lc3b_control_word mk(input logic rd, input logic wr, input logic by, input logic ind);
        lc3b_control_word c;
        c.mem_read     = rd;
        c.mem_write    = wr;
        c.mem_byte     = by;
        c.mem_indirect = ind;
        return c;
    endfunction

    // Called at a negedge in IDLE; acts as memory with latency l0 then l1,
    // returns at the next IDLE negedge with requests and stall cycles recorded.
    task automatic do_op(input lc3b_control_word c, input logic [15:0] a, input logic [15:0] s,
                         input int l0, input logic [15:0] d0, input int l1, input logic [15:0] d1);
        int  w;
        logic done;
        w = 0;
        done = 1'b0;
        n_req = 0;
        n_stall = 0;
        control_in = c;
        alu_in = a;
        sr2_in = s;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (stall) n_stall++;
            if (dmem_read || dmem_write) begin
                if (w == 0) begin
                    if (n_req < 2) begin
                        q_addr[n_req]  = dmem_address;
                        q_wdata[n_req] = dmem_wdata;
                        q_be[n_req]    = dmem_byte_enable;
                        q_rd[n_req]    = dmem_read;
                        q_wr[n_req]    = dmem_write;
                    end
                    n_req++;
                end
                w++;
                if (w == (n_req == 1 ? l0 : l1)) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = (n_req == 1) ? d0 : d1;
                    w = 0;
                end
            end else if (!stall) begin
                done = 1'b1;
            end
            if (!done) begin
                @(negedge clk);
                dmem_resp  = 1'b0;
                dmem_rdata = '0;
            end
        end
        check("op_completes", {31'd0, done}, 32'd1);
        control_in = '0;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        control_in = '0;
        alu_in = '0;
        sr2_in = '0;
        dmem_resp = 1'b0;
        dmem_rdata = '0;
        #1;
        check("rst_stall", stall, 0);
        check("rst_read", dmem_read, 0);
        check("rst_write", dmem_write, 0);
        check("rst_addr", dmem_address, 0);
        check("rst_mdr", mdr_out, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // ADD with a spurious response in IDLE
        control_in = '0;
        dmem_resp = 1'b1;
        dmem_rdata = 16'hDEAD;
        #1;
        check("add_stall", stall, 0);
        check("add_req", {dmem_read, dmem_write}, 0);
        @(negedge clk);
        dmem_resp = 1'b0;
        dmem_rdata = '0;
        #1;
        check("add_stall2", stall, 0);
        check("add_mdr", mdr_out, 0);
        @(negedge clk);

        // LDR, latency 2
        do_op(mk(1, 0, 0, 0), 16'h1235, 16'h0, 2, 16'hBEEF, 1, 16'h0);
        check("ldr_nreq", n_req, 1);
        check("ldr_addr", q_addr[0], 16'h1234);
        check("ldr_be", q_be[0], 2'b11);
        check("ldr_rd", {q_rd[0], q_wr[0]}, 2'b10);
        check("ldr_mdr", mdr_out, 16'hBEEF);
        check("ldr_stall", n_stall, 3);

        // LDB high byte
        do_op(mk(1, 0, 1, 0), 16'h2001, 16'h0, 1, 16'hA55A, 1, 16'h0);
        check("ldb_addr", q_addr[0], 16'h2000);
        check("ldb_mdr", mdr_out, 16'h00A5);
        check("ldb_stall", n_stall, 2);

        // STB low byte
        do_op(mk(0, 1, 1, 0), 16'h2000, 16'h1234, 1, 16'hFFFF, 1, 16'h0);
        check("stb_wr", {q_rd[0], q_wr[0]}, 2'b01);
        check("stb_wdata", q_wdata[0], 16'h3434);
        check("stb_be", q_be[0], 2'b01);
        check("stb_mdr", mdr_out, 16'h00A5);

        // LDI
        do_op(mk(1, 0, 0, 1), 16'h3000, 16'h0, 1, 16'h4002, 2, 16'h7777);
        check("ldi_nreq", n_req, 2);
        check("ldi_addr0", q_addr[0], 16'h3000);
        check("ldi_addr1", q_addr[1], 16'h4002);
        check("ldi_rd", {q_rd[0], q_rd[1], q_wr[0], q_wr[1]}, 4'b1100);
        check("ldi_mdr", mdr_out, 16'h7777);
        check("ldi_stall", n_stall, 4);

        // STI
        do_op(mk(0, 1, 0, 1), 16'h3001, 16'hCAFE, 1, 16'h5000, 1, 16'h0);
        check("sti_nreq", n_req, 2);
        check("sti_ptr_rd", {q_rd[0], q_wr[0], q_be[0]}, 4'b1011);
        check("sti_addr0", q_addr[0], 16'h3000);
        check("sti_addr1", q_addr[1], 16'h5000);
        check("sti_wr", {q_rd[1], q_wr[1]}, 2'b01);
        check("sti_wdata", q_wdata[1], 16'hCAFE);
        check("sti_be", q_be[1], 2'b11);
        check("sti_mdr", mdr_out, 16'h7777);
        check("sti_stall", n_stall, 3);

        // Reset during ACCESS
        control_in = mk(1, 0, 0, 0);
        alu_in = 16'h6000;
        @(negedge clk);
        #1;
        check("rsta_read", dmem_read, 1);
        reset_n = 1'b0;
        #1;
        check("rsta_read0", dmem_read, 0);
        check("rsta_stall", stall, 0);
        check("rsta_mdr", mdr_out, 0);
        control_in = '0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rsta_idle", {stall, dmem_read, dmem_write}, 0);
        @(negedge clk);
        do_op(mk(1, 0, 0, 0), 16'h0010, 16'h0, 1, 16'h1111, 1, 16'h0);
        check("resume_addr", q_addr[0], 16'h0010);
        check("resume_mdr", mdr_out, 16'h1111);
        check("resume_stall", n_stall, 2);

        // Both read and write set: treated as a write
        do_op(mk(1, 1, 0, 0), 16'h0101, 16'hABCD, 1, 16'h9999, 1, 16'h0);
        check("rw_wr", {q_rd[0], q_wr[0]}, 2'b01);
        check("rw_wdata", q_wdata[0], 16'hABCD);
        check("rw_addr", q_addr[0], 16'h0100);
        check("rw_mdr", mdr_out, 16'h1111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage LC-3b pipeline, sitting directly downstream of the EX/MEM barrier and upstream of the MEM/WB barrier. It takes the control word, effective address (ALU result) and store data from EX/MEM and performs LDR/STR/LDB/STB/LDI/STI against the data-memory port. A small FSM handles multi-cycle memory responses and the two-access indirect forms. It asserts `stall` to freeze the upstream barriers until the access completes.

## Interface
Parameters: none. All widths come from `lc3b_types`.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `control_in`  in  `lc3b_control_word`  from EX/MEM; fields used: `mem_read`, `mem_write`, `mem_byte`, `mem_indirect`
- `alu_in`  in  16  effective address
- `sr2_in`  in  16  store data
- `dmem_resp`  in  1  data memory access complete (read data valid / write accepted)
- `dmem_rdata`  in  16  data memory read word
- `dmem_read`  out  1  read request
- `dmem_write`  out  1  write request
- `dmem_address`  out  16  word-aligned address; bit 0 is always 0
- `dmem_wdata`  out  16  write data
- `dmem_byte_enable`  out  2  bit 1 = high byte, bit 0 = low byte
- `mdr_out`  out  16  registered load result, consumed by MEM/WB
- `stall`  out  1  high while a memory op in EX/MEM has not completed

## Operation
- `mem_op` = `mem_read | mem_write`. If both bits are set, the op is treated as a write.
- FSM states:
  - `IDLE`: if `mem_op` and `mem_indirect`, go to `PTR`; else if `mem_op`, go to `ACCESS`; else stay.
  - `PTR`: word read at `{alu_in[15:1],0}`. On `dmem_resp`, latch `ptr <= dmem_rdata` and go to `ACCESS`.
  - `ACCESS`: final access. The address is `ptr` with bit 0 cleared when indirect, else `alu_in` with bit 0 cleared. On `dmem_resp`: for a read, update `mdr`; then go to `DONE`.
  - `DONE`: exactly one cycle, then go to `IDLE`.
- `stall` = `reset_n & ((IDLE & mem_op) | PTR | ACCESS)`. It is low in `DONE`, so the barriers advance on that edge.
- Request outputs are driven only in `PTR` and `ACCESS`. They are held constant until `dmem_resp`. All `dmem_*` outputs are 0 in `IDLE` and `DONE`.
- Word access: `dmem_byte_enable = 2'b11`, `dmem_wdata = sr2_in`.
- Byte store: `dmem_wdata = {sr2_in[7:0], sr2_in[7:0]}`. Byte select comes from address bit 0, i.e. `alu_in[0]` when direct or `ptr[0]` when indirect: 1 gives `2'b10`, 0 gives `2'b01`.
- Byte load: `mdr = ZEXT(selected byte)`. High byte when address bit 0 = 1.
- The `PTR` access is always a full-word read, regardless of `mem_byte`.
- Stores leave `mdr` unchanged.
- `dmem_resp` is ignored in `IDLE` and `DONE`.

## Timing
- Reset (async, takes effect immediately without a clock edge): state `IDLE`, `ptr = 0`, `mdr_out = 0`, `stall = 0`, all `dmem_*` outputs 0.
- Reset asserted mid-`PTR`/`ACCESS` drops the request in the same cycle. No partial `mdr` update occurs.
- Non-memory op: 0 stall cycles, no memory traffic.
- Direct access with response latency L ≥ 1 cycle after entering `ACCESS`: `stall` high for L+1 cycles, then `DONE`.
- Indirect access: `stall` high for 1 + L_ptr + L_access cycles.
- `mdr_out` is valid from the `DONE` cycle onward and stays stable until the next load completes.
- Back-to-back memory ops: the op after `DONE` is seen in `IDLE` on the following cycle. There is no bubble beyond the `IDLE` cycle.

## Structure
- In `lc3b_types`:
  - Add `mem_read`, `mem_write`, `mem_byte` and `mem_indirect` to `lc3b_control_word`.
  - Add `lc3b_mem_state` enum (`IDLE`, `PTR`, `ACCESS`, `DONE`).
- Sub-module `mem_byte_align`, purely combinational:
  - Load path: byte select and zero-extend.
  - Store path: byte replicate and byte-enable generation.
- FSM and the `ptr`/`mdr` registers stay in `mem_stage`.

## Test plan
- LDR: `alu_in = 0x1235`, `rdata = 0xBEEF` after 2 cycles → `dmem_address = 0x1234`, `byte_enable = 11`, `mdr_out = 0xBEEF`, `stall` high for exactly 3 cycles.
- LDB/STB:
  - LDB at `0x2001`, `rdata = 0xA55A` → `mdr_out = 0x00A5`.
  - STB at `0x2000` with `sr2 = 0x1234` → `wdata = 0x3434`, `byte_enable = 01`, `mdr` unchanged.
- LDI: `alu_in = 0x3000`, first `rdata = 0x4002`, second `rdata = 0x7777` → second `dmem_address = 0x4002`, `mdr_out = 0x7777`, two distinct read requests.
- STI: pointer `0x5000`, `sr2 = 0xCAFE` → one read at `alu_in` aligned, then a write at `0x5000` with `wdata = 0xCAFE`, `byte_enable = 11`.
- `reset_n` pulsed low during `ACCESS` with `dmem_read` high → `dmem_read` drops immediately, `stall = 0`, state `IDLE`, `mdr_out = 0`. Ops resume normally after release.
- ADD (no mem bits) followed by LDR → ADD sees `stall = 0` and no requests. LDR stalls normally; spurious `dmem_resp` in `IDLE` is ignored.
